// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and run-control stage (IDLE/RUN/HALT) feeding
// instruction ROM fetch. Consumes ALU branch/control results, owns the
// Start/Ack handshake with the bench and stall handling.
// Optional feature macro: PC_SEQ_CYCLE_CNT_EN adds the CycleCnt retired-count port.
module pc_sequencer #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            IsBranch,
    input  logic [8:0]      bOFFSET,
    input  logic            bSIGN,
    input  logic            AluReset,
    input  logic            AluHalt,
    output logic [PC_W-1:0] PC,
    output logic            Running,
`ifdef PC_SEQ_CYCLE_CNT_EN
    output logic            Ack,
    output logic [15:0]     CycleCnt
`else
    output logic            Ack
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PC_W-1:0] pc_d;
    logic            running_d;
    logic            ack_d;
    logic [PC_W-1:0] start_pc;
    logic [PC_W-1:0] off_ext;

    // Branch offset is an unsigned magnitude; zero-extend to PC width.
    assign start_pc = PC_W'(START_ADDR);
    assign off_ext  = PC_W'(bOFFSET);

    // Next-state and next-PC selection in retirement priority order.
    always_comb begin
        state_d = state_q;
        pc_d    = PC;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = start_pc;
                end else begin
                    pc_d = '0;
                end
            end
            S_RUN: begin
                if (!Stall) begin
                    if (AluReset && AluHalt) begin
                        state_d = S_HALT;
                    end else if (AluReset) begin
                        pc_d = start_pc;
                    end else if (IsBranch) begin
                        pc_d = bSIGN ? (PC - off_ext) : (PC + off_ext);
                    end else begin
                        pc_d = PC + PC_W'(1);
                    end
                end
            end
            S_HALT: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = start_pc;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
        running_d = (state_d == S_RUN);
        ack_d     = (state_d == S_HALT);
    end

    // State, PC and status flags; synchronous reset wins over everything.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            PC      <= '0;
            Running <= 1'b0;
            Ack     <= 1'b0;
        end else begin
            state_q <= state_d;
            PC      <= pc_d;
            Running <= running_d;
            Ack     <= ack_d;
        end
    end

`ifdef PC_SEQ_CYCLE_CNT_EN
    logic             retire;
    logic             restart;
    logic [CNT_W-1:0] cnt_d;

    // An unstalled RUN edge retires one instruction, the halting one included.
    assign retire  = (state_q == S_RUN) && !Stall;
    assign restart = ((state_q == S_IDLE) || (state_q == S_HALT)) && Start;

    // Saturating retired-instruction count, cleared whenever execution restarts.
    always_comb begin
        cnt_d = CycleCnt;
        if (restart) begin
            cnt_d = '0;
        end else if (retire && (CycleCnt != {CNT_W{1'b1}})) begin
            cnt_d = CycleCnt + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            CycleCnt <= '0;
        end else begin
            CycleCnt <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized bench for pc_sequencer with a
// behavioural run-control model checked every cycle.
// Honours PC_SEQ_CYCLE_CNT_EN to also cover the CycleCnt port.
module tb_pc_sequencer;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned START_ADDR = 0;
    localparam int          MODV       = 1 << PC_W;

    logic            CLK;
    logic            rst;
    logic            start;
    logic            stall;
    logic            is_br;
    logic [8:0]      off;
    logic            sgn;
    logic            alu_rst;
    logic            alu_halt;
    logic [PC_W-1:0] pc;
    logic            running;
    logic            ack;
`ifdef PC_SEQ_CYCLE_CNT_EN
    logic [15:0]     cycle_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    // Model state: mode 0 = idle, 1 = run, 2 = halt.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    pc_sequencer #(.PC_W(PC_W), .START_ADDR(START_ADDR)) dut (
        .CLK      (CLK),
        .Reset    (rst),
        .Start    (start),
        .Stall    (stall),
        .IsBranch (is_br),
        .bOFFSET  (off),
        .bSIGN    (sgn),
        .AluReset (alu_rst),
        .AluHalt  (alu_halt),
        .PC       (pc),
        .Running  (running),
`ifdef PC_SEQ_CYCLE_CNT_EN
        .Ack      (ack),
        .CycleCnt (cycle_cnt)
`else
        .Ack      (ack)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic cmp(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: applies the run-control rules to the inputs seen at each edge.
    always @(posedge CLK) begin
        if (rst) begin
            m_mode = 0;
            m_pc   = 0;
            m_cnt  = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_pc   = START_ADDR;
                m_cnt  = 0;
            end
        end else if (m_mode == 2) begin
            if (start) begin
                m_mode = 1;
                m_pc   = START_ADDR;
                m_cnt  = 0;
            end
        end else if (!stall) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (alu_rst && alu_halt)  m_mode = 2;
            else if (alu_rst)         m_pc = START_ADDR;
            else if (is_br && !sgn)   m_pc = (m_pc + int'(off)) % MODV;
            else if (is_br && sgn)    m_pc = (m_pc - int'(off) + MODV) % MODV;
            else                      m_pc = (m_pc + 1) % MODV;
        end
    end

    // Compare DUT against the model on the falling edge, clear of the active edge.
    always @(negedge CLK) begin
        if (check_en) begin
            cmp("pc", int'(pc), m_pc);
            cmp("running", int'(running), (m_mode == 1) ? 1 : 0);
            cmp("ack", int'(ack), (m_mode == 2) ? 1 : 0);
`ifdef PC_SEQ_CYCLE_CNT_EN
            cmp("cycle_cnt", int'(cycle_cnt), m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        rst = 0; start = 0; stall = 0; is_br = 0;
        off = '0; sgn = 0; alu_rst = 0; alu_halt = 0;
    endtask

    task automatic branch(input int o, input bit s);
        is_br = 1; off = 9'(o); sgn = s;
        tick();
    endtask

    initial begin
        quiet();
        rst = 1;
        tick();
        tick();
        check_en = 1;
        cmp("rst_pc", int'(pc), 0);
        cmp("rst_running", int'(running), 0);
        cmp("rst_ack", int'(ack), 0);
        rst = 0;
        tick();
        cmp("idle_pc", int'(pc), 0);

        // Start and five sequential instructions.
        start = 1;
        tick();
        cmp("start_pc", int'(pc), 0);
        cmp("start_running", int'(running), 1);
        start = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            cmp("seq_pc", int'(pc), i);
        end
        cmp("seq_ack", int'(ack), 0);

        // Branch arithmetic including wrap, self-loop and not-taken.
        branch(15, 0);  cmp("br_to20", int'(pc), 20);
        branch(7, 1);   cmp("br_back7", int'(pc), 13);
        branch(300, 0); cmp("br_fwd300", int'(pc), 313);
        branch(511, 0); cmp("br_fwd511", int'(pc), 824);
        branch(196, 0); cmp("br_to1020", int'(pc), 1020);
        branch(10, 0);  cmp("br_wrap", int'(pc), 6);
        branch(0, 0);   cmp("br_self", int'(pc), 6);
        branch(1, 0);   cmp("br_nottaken", int'(pc), 7);
        branch(10, 1);  cmp("br_wrap_back", int'(pc), 1021);
        branch(11, 0);  cmp("br_wrap_fwd", int'(pc), 8);

        // Stall blocks a pending halt; halt takes effect once stall drops.
        is_br = 0; stall = 1; alu_rst = 1; alu_halt = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("stall_pc", int'(pc), 8);
            cmp("stall_running", int'(running), 1);
        end
        stall = 0;
        tick();
        cmp("halt_pc", int'(pc), 8);
        cmp("halt_ack", int'(ack), 1);
        cmp("halt_running", int'(running), 0);
        is_br = 1; off = 9'd5; alu_halt = 0;
        tick();
        tick();
        cmp("halt_frozen", int'(pc), 8);
        quiet();

        // Restart from HALT with Start held: no re-trigger.
        start = 1;
        tick();
        cmp("restart_pc", int'(pc), START_ADDR);
        cmp("restart_ack", int'(ack), 0);
        cmp("restart_running", int'(running), 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            cmp("held_start_pc", int'(pc), i);
        end
        start = 0;

        // Soft reset and hard reset mid-run.
        branch(36, 0);  cmp("to40", int'(pc), 40);
        is_br = 0; alu_rst = 1;
        tick();
        cmp("soft_rst_pc", int'(pc), START_ADDR);
        cmp("soft_rst_running", int'(running), 1);
        alu_rst = 0;
        branch(40, 0);  cmp("to40b", int'(pc), 40);
        is_br = 0; rst = 1;
        tick();
        cmp("hard_rst_pc", int'(pc), 0);
        cmp("hard_rst_running", int'(running), 0);
        cmp("hard_rst_ack", int'(ack), 0);
        quiet();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 7) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            alu_rst  = ($urandom_range(0, 15) == 0);
            alu_halt = ($urandom_range(0, 1) == 0);
            is_br    = ($urandom_range(0, 2) == 0);
            off      = 9'($urandom_range(0, 511));
            sgn      = 1'($urandom_range(0, 1));
            tick();
        end
        quiet();

`ifdef PC_SEQ_CYCLE_CNT_EN
        // Retired count: 10 instructions, 2 stalls, then the halting instruction.
        rst = 1;
        tick();
        rst = 0; start = 1;
        tick();
        start = 0;
        cmp("cnt_start", int'(cycle_cnt), 0);
        for (int i = 0; i < 10; i++) tick();
        cmp("cnt_ten", int'(cycle_cnt), 10);
        stall = 1;
        tick();
        tick();
        stall = 0; alu_rst = 1; alu_halt = 1;
        tick();
        cmp("cnt_halt", int'(cycle_cnt), 11);
        quiet();
        tick();
        cmp("cnt_hold", int'(cycle_cnt), 11);
        start = 1;
        tick();
        cmp("cnt_clear", int'(cycle_cnt), 0);
        quiet();
`endif

        tick();
        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and run-control stage directly upstream of the ALU in the CSE141L core.
- Consumes the ALU's branch outputs (bOFFSET, bSIGN) and its control outputs (reset, halt), and produces the instruction address for instruction ROM fetch.
- Owns the IDLE/RUN/HALT run state, the Start/Ack handshake with the test bench, and stall handling.

Parameters:
- PC_W, 10, program-counter width in bits; must be >= 9.
- START_ADDR, 0, address loaded on Start and on ALU soft reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high; clears all state.
- Start  input  1  level-sampled request to begin execution from START_ADDR.
- Stall  input  1  when high, the current instruction does not retire; PC and state hold.
- IsBranch  input  1  high when the instruction at PC is a branch op (kBRC, kBRR or kBRO).
- bOFFSET  input  9  unsigned branch magnitude from the ALU.
- bSIGN  input  1  1 = backward (subtract), 0 = forward (add).
- AluReset  input  1  ALU reset output (kRST).
- AluHalt  input  1  ALU halt output (kRST with T=1).
- PC  output  PC_W  current instruction address.
- Running  output  1  high in RUN.
- Ack  output  1  high in HALT; tells the bench the program is done.
- CycleCnt  output  16  retired-instruction count; present only with the optional feature.

Behaviour:
- States: IDLE (after Reset), RUN, HALT.
- Reset (synchronous, highest priority):
  - State goes to IDLE; PC, Running, Ack and CycleCnt all go to 0.
  - Reset asserted mid-RUN aborts execution on that edge.
- IDLE:
  - Start=1 → RUN, with PC <= START_ADDR.
  - Otherwise hold; PC=0.
- RUN: per edge, in priority order:
  1. Stall=1 → hold PC and state; ignore all ALU inputs.
  2. AluReset=1 and AluHalt=1 → HALT; PC holds, so PC shows the halting instruction.
  3. AluReset=1 and AluHalt=0 → soft reset: PC <= START_ADDR, stay in RUN.
  4. IsBranch=1 → if bSIGN=0, PC <= PC + bOFFSET; if bSIGN=1, PC <= PC - bOFFSET.
  5. Otherwise PC <= PC + 1.
- Branch arithmetic:
  - bOFFSET is zero-extended to PC_W before the add/subtract.
  - Result is taken modulo 2^PC_W (wrap-around in both directions, no error).
  - A not-taken branch arrives as bOFFSET=1, bSIGN=0, giving PC+1; no special case.
  - bOFFSET=0 with IsBranch=1 means PC holds (self-loop); this is legal.
- HALT:
  - Ack=1, Running=0; PC frozen.
  - Start=1 → RUN with PC <= START_ADDR and Ack cleared on the same edge.
  - ALU inputs are ignored in HALT.
- Outputs are registered only, with no combinational paths from inputs to outputs.
- Latency: a retiring instruction at PC=N updates PC on the next edge. Running and Ack change on the edge that changes state.
- Start held high across a HALT→RUN transition does not re-trigger; Start is only sampled in IDLE and HALT.

Optional Feature:
- Macro: PC_SEQ_CYCLE_CNT_EN.
- Defined:
  - CycleCnt port exists.
  - Increments by 1 on each RUN edge where Stall=0, including the halting instruction.
  - Saturates at 16'hFFFF.
  - Cleared by Reset and on every Start that enters RUN; holds in HALT.
- Undefined: CycleCnt port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then Start=1 for 1 cycle with START_ADDR=0, no branches for 5 cycles → PC goes 0,1,2,3,4,5; Running=1; Ack=0.
- At PC=20: IsBranch=1, bOFFSET=7, bSIGN=1 → PC=13 next; then bOFFSET=300, bSIGN=0 → PC=313. With PC_W=10 at PC=1020: bOFFSET=10, bSIGN=0 → PC=6 (wrap).
- Stall=1 for 3 cycles at PC=8 while AluReset=1, AluHalt=1 → PC stays 8 and state stays RUN; Stall drops with halt still high → HALT, Ack=1, PC=8.
- AluReset=1, AluHalt=0 at PC=40 → PC=START_ADDR, Running=1. Reset asserted at PC=40 mid-RUN → IDLE, PC=0, Running=0, Ack=0 on that edge.
- In HALT, Start=1 → RUN, PC=START_ADDR, Ack=0 the same edge; holding Start for 4 more cycles gives PC=1,2,3,4 (no re-trigger).
- With PC_SEQ_CYCLE_CNT_EN: 10 retiring cycles plus 2 stall cycles, then halt → CycleCnt=11 (10 instructions plus the halting one), held in HALT; cleared to 0 on the next Start.
